gray_seq_ctrl: RTL and testbench

Sequencer that drives a binary count through a Gray encoder and streams the binary/Gray pairs to a consumer over a valid/ready handshake.
- Software programs a first and a last value, a direction follows from them, and the sequence runs once or wraps continuously.
- Typical consumers are Gray-coded pointer/position test paths and encoder exercisers.

---
 rtl/gray_seq_pkg.sv | 11 +
 rtl/gray_seq_ctrl_enc.sv | 13 +
 rtl/gray_seq_ctrl.sv | 97 +++++++++
 tb/tb_gray_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gray_seq_pkg.sv
// Shared constants for the Gray-code sequencer.
// State encodings and the default count width.
package gray_seq_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/gray_seq_ctrl_enc.sv
// Binary to reflected Gray code converter.
// Pure combinational, no state.
module gray_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // adjacent-bit xor gives the reflected code
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Streams a first..last binary count and its Gray code
// over a valid/ready handshake, once or wrapping.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_first,
  input  logic [WIDTH-1:0] cfg_last,
  input  logic             cfg_wrap,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  logic [1:0]       st;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] first_q;
  logic [WIDTH-1:0] last_q;
  logic             wrap_q;
  logic             dir_q;
  logic             run;
  logic             at_last;
  logic             xfer;

  assign run     = (st == ST_RUN);
  assign at_last = (cnt == last_q);
  assign xfer    = run & out_ready;

  // FSM, counter and config latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= ST_IDLE;
      cnt     <= '0;
      first_q <= '0;
      last_q  <= '0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            st      <= ST_RUN;
            cnt     <= cfg_first;
            first_q <= cfg_first;
            last_q  <= cfg_last;
            wrap_q  <= cfg_wrap;
            dir_q   <= (cfg_first > cfg_last);
          end
        end
        ST_RUN: begin
          if (stop) begin
            st <= ST_IDLE;
          end else if (xfer) begin
            if (!at_last) begin
              if (dir_q)
                cnt <= cnt - WIDTH'(1);
              else
                cnt <= cnt + WIDTH'(1);
            end else if (wrap_q) begin
              cnt <= first_q;
            end else begin
              st <= ST_DONE;
            end
          end
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  gray_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .bin  (cnt),
    .gray (out_gray)
  );

  // outputs decoded from registered state
  always_comb begin
    out_valid = run;
    busy      = run;
    done      = (st == ST_DONE);
    out_bin   = cnt;
    out_last  = run & at_last;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: run table plus
// hand sequences, beats checked from a queue.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] cfg_first = '0;
  logic [3:0] cfg_last = '0;
  logic       cfg_wrap = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_bin;
  logic [3:0] out_gray;
  logic       out_last;
  logic       busy;
  logic       done;

  gray_seq_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg_first (cfg_first),
    .cfg_last  (cfg_last),
    .cfg_wrap  (cfg_wrap),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_gray  (out_gray),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       last;
  } beat_t;

  typedef struct {
    logic [3:0] first;
    logic [3:0] last;
    logic       wrap;
    int         nbeats;
    int         ncyc;
    int         stop_at;
    int         glitch_at;
    int         exp_busy;
    int         exp_done;
    int         exp_done_at;
  } run_t;

  beat_t      q[$];
  logic [3:0] lut [16];
  run_t       runs [5];
  int         nvec = 0;
  int         nerr = 0;

  task automatic check(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // scoreboard: a beat seen valid&ready transfers next edge
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL beat_unexpected: got bin %0d expected none",
                 out_bin);
      end else begin
        beat_t b;
        b = q.pop_front();
        check("beat_bin", int'(out_bin), int'(b.bin));
        check("beat_gray", int'(out_gray), int'(b.gray));
        check("beat_last", int'(out_last), int'(b.last));
      end
    end
  end

  task automatic push_beats(logic [3:0] f, logic [3:0] l,
                            int n);
    logic [3:0] c;
    beat_t      b;
    c = f;
    for (int k = 0; k < n; k++) begin
      b.bin  = c;
      b.gray = lut[c];
      b.last = (c == l);
      q.push_back(b);
      if (c == l)      c = f;
      else if (f > l)  c = c - 4'd1;
      else             c = c + 4'd1;
    end
  endtask

  task automatic do_start(logic [3:0] f, logic [3:0] l,
                          logic w);
    @(posedge clk) #1;
    cfg_first = f;
    cfg_last  = l;
    cfg_wrap  = w;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk) #1;
    start     = 1'b0;
    cfg_first = 4'($urandom);
    cfg_last  = 4'($urandom);
    cfg_wrap  = 1'($urandom);
  endtask

  task automatic run_obs(run_t r, output int nb,
                         output int nd, output int dat);
    nb  = 0;
    nd  = 0;
    dat = 0;
    do_start(r.first, r.last, r.wrap);
    for (int i = 1; i <= r.ncyc; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        nd++;
        dat = i;
      end
      if (i == r.stop_at)       stop = 1'b1;
      if (i == r.stop_at + 1)   stop = 1'b0;
      if (i == r.glitch_at) begin
        start     = 1'b1;
        cfg_first = 4'd9;
        cfg_last  = 4'd12;
      end
      if (i == r.glitch_at + 1) start = 1'b0;
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_bin"}, int'(out_bin), 0);
    check({tag, "_gray"}, int'(out_gray), 0);
    check({tag, "_last"}, int'(out_last), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  initial begin
    int nb, nd, dat;
    lut = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
            4'b0110, 4'b0111, 4'b0101, 4'b0100,
            4'b1100, 4'b1101, 4'b1111, 4'b1110,
            4'b1010, 4'b1011, 4'b1001, 4'b1000};
    runs[0] = '{4'd3,  4'd6,  1'b0, 4, 7,  0, 0, 4, 1, 5};
    runs[1] = '{4'd10, 4'd8,  1'b0, 3, 6,  0, 0, 3, 1, 4};
    runs[2] = '{4'd14, 4'd15, 1'b1, 8, 10, 8, 0, 8, 0, 0};
    runs[3] = '{4'd0,  4'd15, 1'b0, 6, 9,  6, 3, 6, 0, 0};
    runs[4] = '{4'd7,  4'd7,  1'b0, 1, 4,  0, 0, 1, 1, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int r = 0; r < 5; r++) begin
      push_beats(runs[r].first, runs[r].last, runs[r].nbeats);
      run_obs(runs[r], nb, nd, dat);
      check($sformatf("run%0d_busy", r), nb, runs[r].exp_busy);
      check($sformatf("run%0d_done", r), nd, runs[r].exp_done);
      check($sformatf("run%0d_done_at", r), dat,
            runs[r].exp_done_at);
      check($sformatf("run%0d_valid_end", r),
            int'(out_valid), 0);
    end

    // backpressure holds beat 1
    push_beats(4'd0, 4'd2, 3);
    do_start(4'd0, 4'd2, 1'b0);
    @(posedge clk) #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_bin", int'(out_bin), 1);
      check("bp_gray", int'(out_gray), 4'b0001);
      check("bp_last", int'(out_last), 0);
    end
    @(posedge clk) #1;
    out_ready = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("bp_done", nd, 1);

    // reset mid-run at out_bin=4
    push_beats(4'd2, 4'd9, 3);
    do_start(4'd2, 4'd9, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;
    push_beats(4'd5, 4'd6, 2);
    run_obs('{4'd5, 4'd6, 1'b0, 2, 5, 0, 0, 2, 1, 3},
            nb, nd, dat);
    check("postrst_busy", nb, 2);
    check("postrst_done_at", dat, 3);

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
